// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: program-counter register and instruction-fetch sequencer.
//
// Holds the PC, runs the imem request/ack handshake, and presents each
// fetched word to decode over valid/ready. Branch/jump redirects from
// execute restart fetch at the new target.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   - a redirect to a non-word-aligned target raises a sticky
//               trap and parks the sequencer in TRAP until reset.
//   undefined - the low two bits of the redirect target are dropped and
//               trap_o is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; start fetching unless stalled
// REQ   | imem_req_o high at pc_o, waiting for imem_ack_i
// HOLD  | fetched word held for decode (inst_valid_o high)
// TRAP  | misaligned redirect seen; fetch halted (macro builds only)

module pc_fetch_seq #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] seq_pc_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i,
    output logic            trap_o
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

    state_t state;
    logic   redirect_act;

    // The fetch address is the PC itself; no separate address register.
    assign imem_addr_o = pc_o;

`ifdef PC_MISALIGN_TRAP_EN
    logic redirect_misaligned;

    // Redirects are ignored once trapped; only reset leaves TRAP.
    assign redirect_act        = redirect_i && (state != TRAP);
    assign redirect_misaligned = |redirect_pc_i[1:0];

    // Sticky trap flag, set by a misaligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_o <= 1'b0;
        end else if (redirect_act && redirect_misaligned) begin
            trap_o <= 1'b1;
        end
    end
`else
    logic [XLEN-1:0] redirect_pc_aligned;
    logic            unused_redirect_lsbs;

    assign redirect_act         = redirect_i;
    assign redirect_pc_aligned  = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign trap_o               = 1'b0;
`endif

    // Fetch FSM: state, PC, held instruction and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_o         <= RESET_VECTOR;
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
        end else if (redirect_act) begin
            // Redirect wins over ack, ready and stall; a coincident ack is dropped.
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            if (redirect_misaligned) begin
                state <= TRAP;
            end else begin
                state <= IDLE;
                pc_o  <= redirect_pc_i;
            end
`else
            state <= IDLE;
            pc_o  <= redirect_pc_aligned;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!stall_i) begin
                        state      <= REQ;
                        imem_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    // Stall is not looked at here: an issued request stays up.
                    if (imem_ack_i) begin
                        state        <= HOLD;
                        imem_req_o   <= 1'b0;
                        inst_valid_o <= 1'b1;
                        inst_o       <= imem_rdata_i;
                        inst_pc_o    <= pc_o;
                    end
                end
                HOLD: begin
                    if (inst_ready_i && !stall_i) begin
                        state        <= REQ;
                        pc_o         <= seq_pc_i;
                        imem_req_o   <= 1'b1;
                        inst_valid_o <= 1'b0;
                    end
                end
`ifdef PC_MISALIGN_TRAP_EN
                TRAP: begin
                    imem_req_o   <= 1'b0;
                    inst_valid_o <= 1'b0;
                end
`endif
                default: begin
                    state        <= IDLE;
                    imem_req_o   <= 1'b0;
                    inst_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Testbench for pc_fetch_seq: directed scenarios followed by a randomized
// run checked against a transaction-level model of the fetch stream.

module tb_pc_fetch_seq;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        ready;
    logic        trap;

    int tests = 0;
    int fails = 0;

    // PC+4 incrementer that sits outside the sequencer.
    assign seq_pc = pc + 32'd4;

    always #5 clk = ~clk;

    pc_fetch_seq #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc),
        .seq_pc_i      (seq_pc),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .inst_valid_o  (valid),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .inst_ready_i  (ready),
        .trap_o        (trap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h13A5_0000);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench on a negedge with rst_n just released and all inputs low.
    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ack         = 1'b0;
        rdata       = 32'h0;
        ready       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc, exp_inst, exp_inst_pc;
        logic        exp_req, exp_valid;

        // ---- reset values and three back-to-back zero-wait fetches ----
        do_reset();
        chk("rst_pc", pc, RV);
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_trap", {31'b0, trap}, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        ack   = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rdata = word_at(32'(4 * k));
            step();
            chk("seq_req", {31'b0, req}, 1);
            chk("seq_addr", addr, 32'(4 * k));
            chk("seq_valid_lo", {31'b0, valid}, 0);
            step();
            chk("seq_valid_hi", {31'b0, valid}, 1);
            chk("seq_req_lo", {31'b0, req}, 0);
            chk("seq_inst_pc", inst_pc, 32'(4 * k));
            chk("seq_inst", inst, word_at(32'(4 * k)));
        end

        // ---- decode back-pressure for 5 cycles ----
        do_reset();
        ack   = 1'b1;
        rdata = 32'h0050_0093;
        step();
        chk("bp_req", {31'b0, req}, 1);
        step();
        chk("bp_valid", {31'b0, valid}, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", {31'b0, valid}, 1);
            chk("bp_hold_inst", inst, 32'h0050_0093);
            chk("bp_hold_pc", pc, 32'h0);
            chk("bp_hold_noreq", {31'b0, req}, 0);
        end
        ready = 1'b1;
        rdata = word_at(32'h4);
        step();
        chk("bp_rel_req", {31'b0, req}, 1);
        chk("bp_rel_addr", addr, 32'h4);

        // ---- redirect coincident with ack drops the data ----
        do_reset();
        ready = 1'b1;
        step();
        chk("rd_req", {31'b0, req}, 1);
        ack         = 1'b1;
        rdata       = 32'hDEAD_BEEF;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        chk("rd_idle_req", {31'b0, req}, 0);
        chk("rd_idle_valid", {31'b0, valid}, 0);
        chk("rd_pc", pc, 32'h100);
        chk("rd_dropped", inst, 32'h0);
        redirect = 1'b0;
        ack      = 1'b0;
        step();
        chk("rd_new_req", {31'b0, req}, 1);
        chk("rd_new_addr", addr, 32'h100);
        ack   = 1'b1;
        rdata = word_at(32'h100);
        step();
        chk("rd_new_inst", inst, word_at(32'h100));
        chk("rd_new_inst_pc", inst_pc, 32'h100);

        // ---- PC wrap from 0xFFFF_FFFC ----
        do_reset();
        ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        chk("wrap_addr_top", addr, 32'hFFFF_FFFC);
        ack   = 1'b1;
        rdata = word_at(32'hFFFF_FFFC);
        step();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        ack = 1'b0;
        step();
        chk("wrap_req", {31'b0, req}, 1);
        chk("wrap_pc", pc, 32'h0);

        // ---- misaligned redirect ----
        do_reset();
        ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_trap", {31'b0, trap}, 1);
        chk("mis_pc_kept", pc, 32'h0);
        redirect = 1'b0;
        ack      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mis_noreq", {31'b0, req}, 0);
            chk("mis_novalid", {31'b0, valid}, 0);
            chk("mis_sticky", {31'b0, trap}, 1);
        end
        ack = 1'b0;
`else
        chk("mis_notrap", {31'b0, trap}, 0);
        chk("mis_pc", pc, 32'h100);
        redirect = 1'b0;
        step();
        chk("mis_req", {31'b0, req}, 1);
        chk("mis_addr", addr, 32'h100);
        chk("mis_notrap2", {31'b0, trap}, 0);
`endif

        // ---- asynchronous reset in the middle of a request ----
        do_reset();
        ack   = 1'b1;
        ready = 1'b1;
        rdata = word_at(32'h0);
        step();
        step();
        ack = 1'b0;
        step();
        chk("ar_req", {31'b0, req}, 1);
        chk("ar_addr", addr, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pc", pc, RV);
        chk("ar_req_clr", {31'b0, req}, 0);
        chk("ar_valid_clr", {31'b0, valid}, 0);
        @(negedge clk);
        ack   = 1'b1;
        rdata = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        step();
        chk("ar_late_novalid", {31'b0, valid}, 0);
        chk("ar_late_req", {31'b0, req}, 1);
        chk("ar_late_inst", inst, 32'h0);
        ack = 1'b0;
        step();
        chk("ar_late_novalid2", {31'b0, valid}, 0);

        // ---- randomized run against the fetch-stream model ----
        do_reset();
        exp_pc      = RV;
        exp_req     = 1'b0;
        exp_valid   = 1'b0;
        exp_inst    = 32'h0;
        exp_inst_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_pc", pc, exp_pc);
            chk("rnd_req", {31'b0, req}, {31'b0, exp_req});
            chk("rnd_valid", {31'b0, valid}, {31'b0, exp_valid});
            chk("rnd_trap", {31'b0, trap}, 0);
            if (exp_req) chk("rnd_addr", addr, exp_pc);
            if (exp_valid) begin
                chk("rnd_inst", inst, exp_inst);
                chk("rnd_inst_pc", inst_pc, exp_inst_pc);
            end

            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            redirect_pc[1:0] = 2'b00;
`endif
            ack   = ($urandom % 3) != 0;
            rdata = $urandom;
            ready = ($urandom % 3) != 0;

            if (redirect) begin
                exp_pc    = redirect_pc & 32'hFFFF_FFFC;
                exp_req   = 1'b0;
                exp_valid = 1'b0;
            end else if (exp_req) begin
                if (ack) begin
                    exp_inst    = rdata;
                    exp_inst_pc = exp_pc;
                    exp_req     = 1'b0;
                    exp_valid   = 1'b1;
                end
            end else if (exp_valid) begin
                if (ready && !stall) begin
                    exp_pc    = exp_inst_pc + 32'd4;
                    exp_valid = 1'b0;
                    exp_req   = 1'b1;
                end
            end else if (!stall) begin
                exp_req = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
# pc_fetch_seq

Program-counter register and instruction-fetch sequencer for the RV32 single-cycle core. Holds the current PC, drives it into the PC+4 incrementer, and loads the incrementer's sum back as the next sequential PC. Runs the instruction-memory request/ack handshake and presents each fetched word to decode over a valid/ready interface. Accepts branch/jump redirects from execute.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded on reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_o` out XLEN: current PC; feeds the incrementer's `a` input. The incrementer's `b` input is the constant 4.
- `seq_pc_i` in XLEN: incrementer sum (pc_o + 4).
- `stall_i` in 1: hazard stall from the core.
- `redirect_i` in 1: taken branch or jump this cycle.
- `redirect_pc_i` in XLEN: redirect target.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out XLEN: fetch address; always equals pc_o.
- `imem_ack_i` in 1: memory returns data this cycle.
- `imem_rdata_i` in 32: instruction word.
- `inst_valid_o` out 1: instruction held for decode.
- `inst_o` out 32: held instruction.
- `inst_pc_o` out XLEN: PC of the held instruction.
- `inst_ready_i` in 1: decode consumes the instruction.
- `trap_o` out 1: misaligned-redirect trap (see Configuration).

## Operation
- FSM states: IDLE, REQ, HOLD, TRAP. TRAP exists only when PC_MISALIGN_TRAP_EN is defined.
- Reset values:
  - State: IDLE.
  - `pc_o`: RESET_VECTOR.
  - `imem_req_o`, `inst_valid_o`, `trap_o`: 0.
  - `inst_o`, `inst_pc_o`: 0.
- IDLE:
  - Outputs: `imem_req_o`=0, `inst_valid_o`=0.
  - Transition: to REQ next cycle unless `stall_i`=1, in which case stay in IDLE.
- REQ:
  - Outputs: `imem_req_o`=1, `imem_addr_o`=pc_o.
  - On `imem_ack_i`: register `inst_o`←imem_rdata_i and `inst_pc_o`←pc_o, then go to HOLD.
  - `stall_i` is ignored in REQ; an issued request is never withdrawn.
- HOLD:
  - Output: `inst_valid_o`=1.
  - Transfer condition: `inst_ready_i`=1 and `stall_i`=0.
  - On transfer: pc←seq_pc_i, go to REQ.
  - Otherwise: hold everything (pc, inst_o, inst_pc_o) stable.
- Redirect rules (`redirect_i`=1, checked in any non-TRAP state):
  - Action: pc←redirect_pc_i, state←IDLE, `inst_valid_o` cleared next cycle.
  - Redirect has priority over `imem_ack_i`, `inst_ready_i` and `stall_i`.
  - An ack arriving in the same cycle as a redirect is discarded.
- PC arithmetic: all updates are modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0; no overflow flag.

## Timing
- First `imem_req_o` is asserted in the 2nd cycle after `rst_n` deasserts (one IDLE cycle).
- Zero-wait memory (ack in the first REQ cycle): `inst_valid_o` asserts the next cycle.
- Steady-state throughput: one instruction per 2 cycles (REQ, HOLD).
- Redirect → new request at the new address after 2 cycles (IDLE, then REQ).
- `rst_n` assertion mid-request: all state clears immediately (asynchronous). A late ack is ignored because the block is then in IDLE.
- All outputs are registered or decoded from state; there is no combinational path from any input to any output.

## Configuration
- Macro: `PC_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with redirect_pc_i[1:0]≠0 does not load the PC.
  - Instead: `trap_o`←1 (sticky), state←TRAP.
  - In TRAP: no requests are issued and `inst_valid_o`=0 until reset.
- Undefined:
  - redirect_pc_i[1:0] is forced to 2'b00 on load.
  - `trap_o` is tied to 0 and the TRAP state is not generated.

## Test plan
- Reset with RESET_VECTOR=0, ack same cycle as each req, `inst_ready_i`=1 → addresses 0x0, 0x4, 0x8 requested; inst_pc_o follows 0x0, 0x4, 0x8; one valid every 2 cycles.
- Hold `inst_ready_i`=0 for 5 cycles with inst 0x00500093 held → inst_o and pc_o stable and no new req; release → next req at 0x4.
- `redirect_i` with target 0x100 in the same cycle as `imem_ack_i` → ack data dropped, IDLE, next req at 0x100.
- pc=0xFFFF_FFFC, advance → pc wraps to 0x0000_0000.
- Redirect to 0x102: with `PC_MISALIGN_TRAP_EN` → trap_o=1 and no further req; without it → req at 0x100, trap_o=0.
- Assert `rst_n`=0 while in REQ with ack pending 2 cycles later → pc=RESET_VECTOR and req=0 immediately; the late ack produces no valid.
